// File: rtl/aes_pkg.sv
// Shared AES types and constants for the inverse-cipher control path.
package aes_pkg;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;
  localparam int AES_RW     = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_KEY = 3'd1,
    INIT     = 3'd2,
    ROUND    = 3'd3,
    FINAL    = 3'd4,
    HOLD     = 3'd5
  } aes_state_e;

endpackage

// File: rtl/aes_round_down_counter.sv
// Loadable RW-bit down counter used as the round key index; saturates at 0.
module aes_round_down_counter #(
  parameter int unsigned    RW      = 4,
  parameter logic [RW-1:0]  RST_VAL = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [RW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [RW-1:0] o_cnt,
  output logic          o_is_one,
  output logic          o_is_zero
);

  logic [RW-1:0] r_cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                   r_cnt <= RST_VAL;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt     = r_cnt;
  assign o_is_one  = (r_cnt == RW'(1));
  assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Round sequencer for the AES inverse cipher: walks the round key index NR..0
// and drives load/round enables plus the block-level valid/ready handshakes.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128,
  parameter int RW = AES_RW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic          i_key_ready,
  output logic [RW-1:0] o_round_idx,
  output logic          o_load_en,
  output logic          o_round_en,
  output logic          o_skip_inv_mix,
  output logic          o_busy,
  output logic          o_out_valid,
  input  logic          i_out_ready
);

  localparam logic [RW-1:0] NR_V = RW'(NR);

  aes_state_e    r_state;
  aes_state_e    w_next;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic [RW-1:0] w_cnt;
  logic          w_is_one;
  logic          w_is_zero;

  // HOLD can hand the slot to a new block in the same cycle the result leaves.
  assign w_in_ready = (r_state == IDLE) || (r_state == HOLD && i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready && !i_flush;

  // State register; reset beats flush, flush is folded into w_next.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and round-index counter control.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_accept) w_next = i_key_ready ? INIT : WAIT_KEY;
      WAIT_KEY: if (i_key_ready) w_next = INIT;
      INIT:     w_next = ROUND;
      ROUND:    if (w_is_one) w_next = FINAL;
      FINAL:    w_next = HOLD;
      HOLD: begin
        if (i_out_ready) begin
          if (w_accept) w_next = i_key_ready ? INIT : WAIT_KEY;
          else          w_next = IDLE;
        end
      end
      default:  w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;

    // Index sits at NR whenever a block is pending (key prefetch), counts
    // down through the rounds and rests at 0 while the result is held.
    w_cnt_load = (w_next == IDLE) || (w_next == WAIT_KEY) || (w_next == INIT);
    w_cnt_dec  = (w_next == ROUND) || (w_next == FINAL);
  end

  aes_round_down_counter #(
    .RW      (RW),
    .RST_VAL (NR_V)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_cnt_load),
    .i_load_val (NR_V),
    .i_dec      (w_cnt_dec),
    .o_cnt      (w_cnt),
    .o_is_one   (w_is_one),
    .o_is_zero  (w_is_zero)
  );

  assign o_in_ready     = w_in_ready;
  assign o_round_idx    = w_cnt;
  assign o_load_en      = (r_state == INIT);
  assign o_round_en     = (r_state == ROUND) || (r_state == FINAL);
  assign o_skip_inv_mix = (r_state == FINAL) && w_is_zero;
  assign o_busy         = (r_state != IDLE);
  assign o_out_valid    = (r_state == HOLD);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl (NR=10 and NR=14 instances).
// Stimulus pushes expected load/out_valid cycles into per-DUT queues; a
// negedge monitor tracks each block and checks it when out_valid rises.
module tb_aes_inv_round_ctrl;

  typedef struct { int ld_cyc; int ov_cyc; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic key_ready = 1'b1, out_ready = 1'b1, iv10 = 1'b0, iv14 = 1'b0;

  logic       ir10, ld10, re10, sk10, bz10, ov10;
  logic [3:0] idx10;
  logic       ir14, ld14, re14, sk14, bz14, ov14;
  logic [3:0] idx14;

  aes_inv_round_ctrl #(.NR(10), .RW(4)) dut10 (
    .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_in_valid(iv10),
    .o_in_ready(ir10), .i_key_ready(key_ready), .o_round_idx(idx10),
    .o_load_en(ld10), .o_round_en(re10), .o_skip_inv_mix(sk10),
    .o_busy(bz10), .o_out_valid(ov10), .i_out_ready(out_ready));

  aes_inv_round_ctrl #(.NR(14), .RW(4)) dut14 (
    .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_in_valid(iv14),
    .o_in_ready(ir14), .i_key_ready(key_ready), .o_round_idx(idx14),
    .o_load_en(ld14), .o_round_en(re14), .o_skip_inv_mix(sk14),
    .o_busy(bz14), .o_out_valid(ov14), .i_out_ready(out_ready));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  exp_t q10[$], q14[$];

  function automatic void chk(string n, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  // Per-DUT block tracking state, index 0 = NR10, 1 = NR14.
  int   ld_cyc [2];
  int   nre    [2];
  int   nsk    [2];
  int   ierr   [2];
  int   exp_idx[2];
  logic ov_q   [2] = '{1'b0, 1'b0};

  task automatic mon(input int d, input int nr, input logic ld, input logic re,
                     input logic sk, input logic ov, input logic [3:0] idx);
    exp_t e;
    if (ld === 1'b1) begin
      ld_cyc[d] = cyc; nre[d] = 0; nsk[d] = 0; ierr[d] = 0; exp_idx[d] = nr - 1;
      if (re !== 1'b0) ierr[d]++;
      if (int'(idx) != nr) ierr[d]++;
    end
    if (re === 1'b1) begin
      if (int'(idx) != exp_idx[d]) ierr[d]++;
      exp_idx[d]--;
      nre[d]++;
    end
    if (sk === 1'b1) begin
      nsk[d]++;
      if (re !== 1'b1 || idx != 4'd0) ierr[d]++;
    end
    if (ov === 1'b1 && ov_q[d] !== 1'b1) begin
      if (d == 0 && q10.size() != 0)      begin e = q10.pop_front(); end
      else if (d == 1 && q14.size() != 0) begin e = q14.pop_front(); end
      else begin
        nvec++; nerr++;
        $display("FAIL unexpected_out_valid dut%0d: got 1 expected 0 (cycle %0d)", d, cyc);
        ov_q[d] = ov;
        return;
      end
      chk($sformatf("load_cycle_d%0d", d), ld_cyc[d], e.ld_cyc);
      chk($sformatf("out_valid_cycle_d%0d", d), cyc, e.ov_cyc);
      chk($sformatf("round_en_pulses_d%0d", d), nre[d], nr);
      chk($sformatf("skip_pulses_d%0d", d), nsk[d], 1);
      chk($sformatf("idx_seq_errors_d%0d", d), ierr[d], 0);
    end
    ov_q[d] = ov;
  endtask

  always @(negedge clk) begin
    mon(0, 10, ld10, re10, sk10, ov10, idx10);
    mon(1, 14, ld14, re14, sk14, ov14, idx14);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    // Reset, then idle checks
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(ir10), 1);
    chk("rst_busy", int'(bz10), 0);
    chk("rst_round_idx", int'(idx10), 10);
    chk("rst_out_valid", int'(ov10), 0);
    chk("rst_load_en", int'(ld10), 0);
    chk("rst_round_en", int'(re10), 0);

    // Single block, key ready
    tick; c = cyc; iv10 = 1'b1; q10.push_back('{c + 1, c + 12});
    tick; iv10 = 1'b0;
    tick(3);
    @(negedge clk);
    chk("run_busy", int'(bz10), 1);
    chk("run_in_ready", int'(ir10), 0);
    tick(12);

    // Key not ready at accept, raised 5 cycles later
    c = cyc; key_ready = 1'b0; iv10 = 1'b1; q10.push_back('{c + 6, c + 17});
    tick; iv10 = 1'b0;
    @(negedge clk);
    chk("waitkey_idx", int'(idx10), 10);
    chk("waitkey_busy", int'(bz10), 1);
    chk("waitkey_load_en", int'(ld10), 0);
    tick(4); key_ready = 1'b1;
    tick(15);

    // Back-pressure in HOLD, then back-to-back acceptance
    out_ready = 1'b0;
    c = cyc; iv10 = 1'b1; q10.push_back('{c + 1, c + 12});
    tick; iv10 = 1'b0;
    tick(11); iv10 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(ov10), 1);
      chk("hold_in_ready", int'(ir10), 0);
      tick;
    end
    out_ready = 1'b1; q10.push_back('{c + 16, c + 27});
    @(negedge clk);
    chk("hold_release_in_ready", int'(ir10), 1);
    tick; iv10 = 1'b0;
    @(negedge clk);
    chk("b2b_load_en", int'(ld10), 1);
    tick(14);

    // Flush mid-ROUND at round_idx 5
    c = cyc; iv10 = 1'b1;
    tick; iv10 = 1'b0;
    tick(5);
    @(negedge clk);
    chk("pre_flush_idx", int'(idx10), 5);
    flush = 1'b1;
    tick; flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", int'(bz10), 0);
    chk("flush_idx", int'(idx10), 10);
    chk("flush_out_valid", int'(ov10), 0);
    chk("flush_in_ready", int'(ir10), 1);
    tick(15);

    // Flush together with an accept in IDLE: accept discarded
    iv10 = 1'b1; flush = 1'b1;
    tick; iv10 = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_busy", int'(bz10), 0);
    chk("flush_accept_load_en", int'(ld10), 0);
    tick(2);

    // Reset mid-ROUND
    iv10 = 1'b1;
    tick; iv10 = 1'b0;
    tick(5);
    @(negedge clk);
    rst_n = 1'b0;
    tick; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(bz10), 0);
    chk("midrst_idx", int'(idx10), 10);
    chk("midrst_out_valid", int'(ov10), 0);
    chk("midrst_in_ready", int'(ir10), 1);
    tick(15);

    // NR=14 run
    c = cyc; iv14 = 1'b1; q14.push_back('{c + 1, c + 16});
    tick; iv14 = 1'b0;
    tick(20);

    chk("q10_drained", q10.size(), 0);
    chk("q14_drained", q14.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
